// File: rtl/dds_sweep_ctrl.sv
`timescale 1ns/1ps
// Stepped-frequency sweep controller that drives the DDS core's magnitude and phase-increment inputs.
// A shadow configuration is loaded while idle. A start command replays it as a single, repeating, ping-pong or static sweep.
module dds_sweep_ctrl #(
    parameter int PHASE_W = 24,
    parameter int MAG_W   = 32,
    parameter int DWELL_W = 16
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               io_cfg_valid,
    output logic               io_cfg_ready,
    input  logic [PHASE_W-1:0] io_cfg_start,
    input  logic [PHASE_W-1:0] io_cfg_stop,
    input  logic [PHASE_W-1:0] io_cfg_step,
    input  logic [DWELL_W-1:0] io_cfg_dwell,
    input  logic [MAG_W-1:0]   io_cfg_mag,
    input  logic [1:0]         io_cfg_mode,
    input  logic               io_start,
    input  logic               io_abort,
    output logic [MAG_W-1:0]   io_mag_value,
    output logic [PHASE_W-1:0] io_phase_delta,
    output logic               io_busy,
    output logic               io_done,
    output logic               io_wrap
);

    typedef enum logic {IDLE, RUN} state_t;
    typedef enum logic [1:0] {MODE_SINGLE, MODE_REPEAT, MODE_PINGPONG, MODE_STATIC} mode_t;

    state_t             state;
    mode_t              sh_mode;
    logic [PHASE_W-1:0] sh_start, sh_stop, sh_step;
    logic [DWELL_W-1:0] sh_dwell;
    logic [MAG_W-1:0]   sh_mag;

    logic [DWELL_W-1:0] dwell_cnt;
    logic [PHASE_W-1:0] target, origin;
    logic               dir_up;
    logic [DWELL_W-1:0] dwell_load;

    assign io_cfg_ready = (state == IDLE);
    assign dwell_load   = (sh_dwell == '0) ? DWELL_W'(1) : sh_dwell;

    // One step toward tgt, computed one bit wider. The result clamps to tgt on
    // overshoot, carry or borrow, so the output never wraps modulo 2^PHASE_W.
    function automatic logic [PHASE_W-1:0] step_toward(
        input logic [PHASE_W-1:0] cur,
        input logic [PHASE_W-1:0] tgt,
        input logic               up,
        input logic [PHASE_W-1:0] stp
    );
        logic [PHASE_W:0] nxt;
        if (stp == '0) return tgt;
        if (up) begin
            nxt = {1'b0, cur} + {1'b0, stp};
            return (nxt > {1'b0, tgt}) ? tgt : nxt[PHASE_W-1:0];
        end
        nxt = {1'b0, cur} - {1'b0, stp};
        return (nxt[PHASE_W] || nxt[PHASE_W-1:0] < tgt) ? tgt : nxt[PHASE_W-1:0];
    endfunction

    // NOTE: every register here, the shadow config included, is a plain flop with
    // an async clear. The clear gives a never-configured start a defined all-zero sweep.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state          <= IDLE;
            sh_mode        <= MODE_SINGLE;
            sh_start       <= '0;
            sh_stop        <= '0;
            sh_step        <= '0;
            sh_dwell       <= '0;
            sh_mag         <= '0;
            dwell_cnt      <= '0;
            target         <= '0;
            origin         <= '0;
            dir_up         <= 1'b0;
            io_phase_delta <= '0;
            io_mag_value   <= '0;
            io_busy        <= 1'b0;
            io_done        <= 1'b0;
            io_wrap        <= 1'b0;
        end else begin
            io_done <= 1'b0;
            io_wrap <= 1'b0;

            if (state == IDLE && io_cfg_valid) begin
                sh_start <= io_cfg_start;
                sh_stop  <= io_cfg_stop;
                sh_step  <= io_cfg_step;
                sh_dwell <= io_cfg_dwell;
                sh_mag   <= io_cfg_mag;
                sh_mode  <= mode_t'(io_cfg_mode);
            end

            if (io_abort) begin
                state          <= IDLE;
                io_phase_delta <= '0;
                io_mag_value   <= '0;
                io_busy        <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (io_start) begin
                            state          <= RUN;
                            io_busy        <= 1'b1;
                            io_phase_delta <= sh_start;
                            io_mag_value   <= sh_mag;
                            dwell_cnt      <= dwell_load;
                            dir_up         <= (sh_start <= sh_stop);
                            target         <= sh_stop;
                            origin         <= sh_start;
                        end
                    end
                    RUN: begin
                        if (sh_mode != MODE_STATIC) begin
                            if (dwell_cnt > DWELL_W'(1)) begin
                                dwell_cnt <= dwell_cnt - DWELL_W'(1);
                            end else begin
                                dwell_cnt <= dwell_load;
                                if (io_phase_delta == target) begin
                                    case (sh_mode)
                                        MODE_SINGLE: begin
                                            state   <= IDLE;
                                            io_busy <= 1'b0;
                                            io_done <= 1'b1;
                                        end
                                        MODE_REPEAT: begin
                                            io_phase_delta <= sh_start;
                                            io_wrap        <= 1'b1;
                                        end
                                        MODE_PINGPONG: begin
                                            // Reverse and step straight off the endpoint so it is not emitted twice.
                                            target         <= origin;
                                            origin         <= target;
                                            dir_up         <= !dir_up;
                                            io_phase_delta <= step_toward(io_phase_delta, origin, !dir_up, sh_step);
                                            io_wrap        <= 1'b1;
                                        end
                                        MODE_STATIC: ;
                                    endcase
                                end else begin
                                    io_phase_delta <= step_toward(io_phase_delta, target, dir_up, sh_step);
                                end
                            end
                        end
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
`timescale 1ns/1ps
// Bench for dds_sweep_ctrl. Each scenario pushes its expected per-cycle outputs to a scoreboard.
// The scoreboard is drained and compared one entry per clock, sampled on the falling edge.
module tb_dds_sweep_ctrl;

    logic        clock = 1'b0;
    logic        reset;
    logic        io_cfg_valid, io_cfg_ready;
    logic [23:0] io_cfg_start, io_cfg_stop, io_cfg_step;
    logic [15:0] io_cfg_dwell;
    logic [31:0] io_cfg_mag;
    logic [1:0]  io_cfg_mode;
    logic        io_start, io_abort;
    logic [31:0] io_mag_value;
    logic [23:0] io_phase_delta;
    logic        io_busy, io_done, io_wrap;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [23:0] phase;
        logic [31:0] mag;
        logic        busy;
        logic        done;
        logic        wrap;
    } exp_t;

    exp_t exp_q[$];

    dds_sweep_ctrl dut (
        .clock          (clock),
        .reset          (reset),
        .io_cfg_valid   (io_cfg_valid),
        .io_cfg_ready   (io_cfg_ready),
        .io_cfg_start   (io_cfg_start),
        .io_cfg_stop    (io_cfg_stop),
        .io_cfg_step    (io_cfg_step),
        .io_cfg_dwell   (io_cfg_dwell),
        .io_cfg_mag     (io_cfg_mag),
        .io_cfg_mode    (io_cfg_mode),
        .io_start       (io_start),
        .io_abort       (io_abort),
        .io_mag_value   (io_mag_value),
        .io_phase_delta (io_phase_delta),
        .io_busy        (io_busy),
        .io_done        (io_done),
        .io_wrap        (io_wrap)
    );

    always #5 clock = ~clock;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic push_entry(input logic [23:0] ph, input logic [31:0] mg,
                              input logic b, input logic d, input logic w);
        exp_t e;
        e.phase = ph; e.mag = mg; e.busy = b; e.done = d; e.wrap = w;
        exp_q.push_back(e);
    endtask

    // One sweep value held for dwell cycles. A wrap pulse is expected on its first cycle only.
    task automatic push_val(input logic [23:0] ph, input logic [31:0] mg,
                            input int dwell, input logic wrap_first);
        for (int i = 0; i < dwell; i++)
            push_entry(ph, mg, 1'b1, 1'b0, (i == 0) ? wrap_first : 1'b0);
    endtask

    task automatic drain(input string name);
        exp_t e;
        int   cyc = 0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (io_phase_delta !== e.phase || io_mag_value !== e.mag || io_busy !== e.busy ||
                io_done !== e.done || io_wrap !== e.wrap) begin
                errors++;
                $display("FAIL %s cycle %0d: got phase=%h mag=%h busy=%b done=%b wrap=%b, want phase=%h mag=%h busy=%b done=%b wrap=%b",
                         name, cyc, io_phase_delta, io_mag_value, io_busy, io_done, io_wrap,
                         e.phase, e.mag, e.busy, e.done, e.wrap);
            end
            cyc++;
            @(negedge clock);
        end
    endtask

    task automatic cfg(input logic [23:0] st, input logic [23:0] sp, input logic [23:0] stp,
                       input logic [15:0] dw, input logic [31:0] mg, input logic [1:0] md);
        io_cfg_start = st; io_cfg_stop = sp; io_cfg_step = stp;
        io_cfg_dwell = dw; io_cfg_mag = mg; io_cfg_mode = md;
        io_cfg_valid = 1'b1;
        @(negedge clock);
        io_cfg_valid = 1'b0;
    endtask

    task automatic go();
        io_start = 1'b1;
        @(negedge clock);
        io_start = 1'b0;
    endtask

    task automatic abort_and_check(input string name);
        io_abort = 1'b1;
        @(negedge clock);
        io_abort = 1'b0;
        checks++;
        if (io_phase_delta !== 24'h0 || io_mag_value !== 32'h0 || io_busy !== 1'b0 || io_done !== 1'b0) begin
            errors++;
            $display("FAIL %s abort: got phase=%h mag=%h busy=%b done=%b, want all zero",
                     name, io_phase_delta, io_mag_value, io_busy, io_done);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        #1;
        checks++;
        if (io_phase_delta !== 24'h0 || io_mag_value !== 32'h0 || io_busy !== 1'b0 ||
            io_done !== 1'b0 || io_wrap !== 1'b0 || io_cfg_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_state: got phase=%h mag=%h busy=%b done=%b wrap=%b ready=%b, want zeros and ready=1",
                     io_phase_delta, io_mag_value, io_busy, io_done, io_wrap, io_cfg_ready);
        end
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
    endtask

    task automatic test_single_up();
        cfg(24'h0, 24'h1000, 24'h600, 16'd3, 32'h100000, 2'd0);
        go();
        checks++;
        if (io_cfg_ready !== 1'b0) begin
            errors++;
            $display("FAIL single_up ready_in_run: got %b want 0", io_cfg_ready);
        end
        push_val(24'h000,  32'h100000, 3, 1'b0);
        push_val(24'h600,  32'h100000, 3, 1'b0);
        push_val(24'hC00,  32'h100000, 3, 1'b0);
        push_val(24'h1000, 32'h100000, 3, 1'b0);
        push_entry(24'h1000, 32'h100000, 1'b0, 1'b1, 1'b0);
        push_entry(24'h1000, 32'h100000, 1'b0, 1'b0, 1'b0);
        drain("single_up");
    endtask

    task automatic test_repeat_down();
        cfg(24'h1000, 24'h800, 24'h400, 16'd1, 32'hABC, 2'd1);
        go();
        for (int r = 0; r < 3; r++) begin
            push_val(24'h1000, 32'hABC, 1, (r != 0));
            push_val(24'hC00,  32'hABC, 1, 1'b0);
            push_val(24'h800,  32'hABC, 1, 1'b0);
        end
        push_val(24'h1000, 32'hABC, 1, 1'b1);
        drain("repeat_down");
        abort_and_check("repeat_down");
    endtask

    task automatic test_ping_pong();
        cfg(24'h0, 24'h800, 24'h400, 16'd2, 32'h55, 2'd2);
        go();
        push_val(24'h000, 32'h55, 2, 1'b0);
        push_val(24'h400, 32'h55, 2, 1'b0);
        push_val(24'h800, 32'h55, 2, 1'b0);
        push_val(24'h400, 32'h55, 2, 1'b1);
        push_val(24'h000, 32'h55, 2, 1'b0);
        push_val(24'h400, 32'h55, 2, 1'b1);
        push_val(24'h800, 32'h55, 2, 1'b0);
        push_val(24'h400, 32'h55, 2, 1'b1);
        drain("ping_pong");
        abort_and_check("ping_pong");
    endtask

    task automatic test_saturation();
        cfg(24'hFFF000, 24'hFFFFFF, 24'h800, 16'd1, 32'h7, 2'd0);
        go();
        push_val(24'hFFF000, 32'h7, 1, 1'b0);
        push_val(24'hFFF800, 32'h7, 1, 1'b0);
        push_val(24'hFFFFFF, 32'h7, 1, 1'b0);
        push_entry(24'hFFFFFF, 32'h7, 1'b0, 1'b1, 1'b0);
        push_entry(24'hFFFFFF, 32'h7, 1'b0, 1'b0, 1'b0);
        drain("saturation");
    endtask

    task automatic test_static();
        cfg(24'h123, 24'h456, 24'h1, 16'd1, 32'h9, 2'd3);
        go();
        push_val(24'h123, 32'h9, 10, 1'b0);
        drain("static");
        abort_and_check("static");
    endtask

    task automatic test_control();
        cfg(24'h200, 24'h200, 24'h10, 16'd2, 32'h5, 2'd1);
        go();
        // Offer a different config while running. It must be refused.
        io_cfg_start = 24'h999; io_cfg_stop = 24'h999; io_cfg_mag = 32'hDEAD;
        io_cfg_mode = 2'd0; io_cfg_dwell = 16'd1;
        io_cfg_valid = 1'b1;
        checks++;
        if (io_cfg_ready !== 1'b0) begin
            errors++;
            $display("FAIL control ready_in_run: got %b want 0", io_cfg_ready);
        end
        push_val(24'h200, 32'h5, 2, 1'b0);
        push_val(24'h200, 32'h5, 2, 1'b1);
        push_val(24'h200, 32'h5, 2, 1'b1);
        drain("control_equal_endpoints");
        io_cfg_valid = 1'b0;
        abort_and_check("control_mid");
        go();
        push_val(24'h200, 32'h5, 2, 1'b0);
        drain("control_shadow_kept");
        abort_and_check("control_restart");
        io_start = 1'b1;
        io_abort = 1'b1;
        @(negedge clock);
        io_start = 1'b0;
        io_abort = 1'b0;
        checks++;
        if (io_busy !== 1'b0 || io_phase_delta !== 24'h0 || io_cfg_ready !== 1'b1) begin
            errors++;
            $display("FAIL start_with_abort: got busy=%b phase=%h ready=%b, want busy=0 phase=0 ready=1",
                     io_busy, io_phase_delta, io_cfg_ready);
        end
        @(negedge clock);
    endtask

    task automatic test_back_to_back();
        cfg(24'h10, 24'h10, 24'h1, 16'd1, 32'h1, 2'd0);
        io_cfg_start = 24'h20; io_cfg_stop = 24'h20; io_cfg_mag = 32'h2;
        io_cfg_valid = 1'b1;
        io_start = 1'b1;
        @(negedge clock);
        io_cfg_valid = 1'b0;
        io_start = 1'b0;
        push_entry(24'h10, 32'h1, 1'b1, 1'b0, 1'b0);
        push_entry(24'h10, 32'h1, 1'b0, 1'b1, 1'b0);
        drain("b2b_old_config");
        go();
        push_entry(24'h20, 32'h2, 1'b1, 1'b0, 1'b0);
        push_entry(24'h20, 32'h2, 1'b0, 1'b1, 1'b0);
        drain("b2b_new_config");
    endtask

    task automatic test_reset_mid();
        cfg(24'h321, 24'h400, 24'h1, 16'd4, 32'h77, 2'd3);
        go();
        push_val(24'h321, 32'h77, 3, 1'b0);
        drain("reset_mid_pre");
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if (io_phase_delta !== 24'h0 || io_mag_value !== 32'h0 || io_busy !== 1'b0 || io_cfg_ready !== 1'b1) begin
            errors++;
            $display("FAIL async_reset: got phase=%h mag=%h busy=%b ready=%b, want zeros and ready=1",
                     io_phase_delta, io_mag_value, io_busy, io_cfg_ready);
        end
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        go();
        push_entry(24'h0, 32'h0, 1'b1, 1'b0, 1'b0);
        push_entry(24'h0, 32'h0, 1'b0, 1'b1, 1'b0);
        push_entry(24'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        drain("zeroed_shadow");
    endtask

    initial begin
        io_cfg_valid = 1'b0; io_cfg_start = '0; io_cfg_stop = '0; io_cfg_step = '0;
        io_cfg_dwell = '0; io_cfg_mag = '0; io_cfg_mode = '0;
        io_start = 1'b0; io_abort = 1'b0;
        test_reset();
        test_single_up();
        test_repeat_down();
        test_ping_pong();
        test_saturation();
        test_static();
        test_control();
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dds_sweep_ctrl.md
# dds_sweep_ctrl

Sweep controller for the trigonometric DDS core. Holds a shadow configuration loaded over a valid/ready port. On command, drives the core's `io_mag_value` / `io_phase_delta` inputs through a stepped frequency sweep with programmable dwell. Modes are single-shot, repeating sawtooth, ping-pong and static tone. Sits directly in front of the DDS core; its outputs connect to the core's magnitude and phase-increment inputs.

## Interface
- `PHASE_W`, 24, phase-increment width (matches DDS `io_phase_delta`)
- `MAG_W`, 32, magnitude width (matches DDS `io_mag_value`)
- `DWELL_W`, 16, dwell counter width

- `clock`  in  1  sole clock, rising edge
- `reset`  in  1  asynchronous, active-low reset
- `io_cfg_valid`  in  1  config word valid
- `io_cfg_ready`  out  1  config accepted when valid&&ready
- `io_cfg_start`  in  PHASE_W  first phase increment
- `io_cfg_stop`  in  PHASE_W  final phase increment (exact endpoint)
- `io_cfg_step`  in  PHASE_W  unsigned step magnitude
- `io_cfg_dwell`  in  DWELL_W  cycles per value (0 treated as 1)
- `io_cfg_mag`  in  MAG_W  output magnitude during sweep
- `io_cfg_mode`  in  2  0 single, 1 repeat, 2 ping-pong, 3 static
- `io_start`  in  1  begin sweep (sampled in IDLE only)
- `io_abort`  in  1  stop and mute, any state
- `io_mag_value`  out  MAG_W  to DDS core
- `io_phase_delta`  out  PHASE_W  to DDS core
- `io_busy`  out  1  high in RUN
- `io_done`  out  1  one-cycle pulse, single-mode completion
- `io_wrap`  out  1  one-cycle pulse on repeat reload / ping-pong reversal

## Operation
- States: IDLE, RUN. All outputs registered except `io_cfg_ready` = (state==IDLE).
- IDLE: `io_cfg_valid && io_cfg_ready` latches all `io_cfg_*` into shadow registers. The config port is ignored while in RUN.
- IDLE + `io_start` + !`io_abort` -> RUN:
  - `io_phase_delta` <= shadow start; `io_mag_value` <= shadow mag.
  - Dwell counter <= max(dwell,1).
  - Direction = up if start<=stop, else down.
- RUN: the counter decrements each cycle. When a value's dwell expires, the next value is computed:
  - Arithmetic is in PHASE_W+1 bits, unsigned. next = delta±step.
  - If next passes stop, or the add carries out / the subtract borrows, next = stop exactly. The output never wraps modulo 2^PHASE_W.
  - step==0: next = stop.
- Endpoint = the current value equals the active target and its dwell has expired. Behaviour by mode:
  - Mode 0: -> IDLE, `io_done` pulse, outputs hold stop.
  - Mode 1: next value = start, `io_wrap` pulse.
  - Mode 2: swap target (stop<->start), reverse direction, `io_wrap` pulse. The endpoint value is not repeated.
  - Mode 3: the output holds start indefinitely; no stepping, no done/wrap.
- start==stop in modes 0-2: emits a single value. Mode 0 then finishes; modes 1-2 re-emit it every dwell with a wrap pulse.
- `io_abort` (any state) -> IDLE next edge; `io_phase_delta`=0, `io_mag_value`=0, busy=0, no done pulse. Abort wins over a simultaneous start.
- Never-configured shadow is all-zero: a start emits 0 for 1 cycle, then done.

## Timing
- Reset (async assert): state IDLE, shadow config 0, all outputs 0, `io_cfg_ready`=1. Mid-sweep reset clears the outputs immediately, without a clock edge.
- `io_start` sampled at edge T: from T+1, outputs = start, busy=1.
- Each value is held exactly max(dwell,1) cycles. The next value appears on the edge after the final dwell cycle.
- Single-mode completion: `io_done`=1 and busy=0 in the same cycle, immediately after stop's last dwell cycle. Outputs hold stop.
- `io_wrap` is asserted in the first cycle of the post-endpoint value.
- Config is accepted in the same cycle as `io_start`. The start uses the previously latched shadow; the new config applies to the next start.

## Test plan
- Single up: start 0, stop 0x1000, step 0x600, dwell 3, mag 0x100000, start at T -> 0x000, 0x600, 0xC00, 0x1000, 3 cycles each from T+1. `io_done` at T+13. Outputs hold 0x1000 with mag 0x100000.
- Repeat down: start 0x1000, stop 0x800, step 0x400, dwell 1 -> 0x1000, 0xC00, 0x800, 0x1000, ... `io_wrap` high on each 0x1000 after the first.
- Ping-pong: start 0, stop 0x800, step 0x400, dwell 2 -> 0, 0x400, 0x800, 0x400, 0, 0x400, ... 2 cycles each. `io_wrap` on the first 0x400 after each endpoint.
- Saturation: start 0xFFF000, stop 0xFFFFFF, step 0x800, mode 0 -> 0xFFF000, 0xFFF800, 0xFFFFFF, done. No value below 0xFFF000 appears.
- Control: `io_cfg_valid` during RUN leaves shadow unchanged (ready=0). `io_abort` mid-sweep -> outputs 0 and busy 0 next cycle. Start+abort in the same cycle -> stays IDLE.
- Async reset asserted mid-sweep between edges -> all outputs 0 immediately. After release, ready=1 and the shadow is zeroed.
